// File: rtl/axis_1553_msg_encoder_pkg.sv
// encoder_1553_pkg: shared constants, types and word-pattern builder for the 1553 message encoder
package encoder_1553_pkg;

  localparam logic [2:0] CMD_SYNC = 3'b100;
  localparam logic [2:0] DATA_SYNC = 3'b010;

  localparam int TU_SYNC_LO = 5;
  localparam int TU_BUS = 3;
  localparam int TU_INV_DATA = 1;
  localparam int TU_INV_PAR = 0;

  localparam int HALF_BITS_PER_WORD = 40;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  typedef struct packed {
    logic last;
    logic [2:0] sync;
    logic bus;
    logic inv_data;
    logic inv_par;
    logic [15:0] data;
  } word_t;

  // Half-bit line levels for one word, MSB first: 6 sync, 16 Manchester data bits, parity bit
  function automatic logic [HALF_BITS_PER_WORD-1:0] build_word(input word_t w);
    logic [15:0] d;
    logic p;
    logic [HALF_BITS_PER_WORD-1:0] r;
    d = w.inv_data ? ~w.data : w.data;
    p = ~(^d) ^ w.inv_par;
    r[39:34] = w.sync == CMD_SYNC ? 6'b111000 : w.sync == DATA_SYNC ? 6'b000111 : 6'b000000;
    for (int i = 0; i < 16; i++) r[33-2*i -: 2] = d[15-i] ? 2'b10 : 2'b01;
    r[1:0] = p ? 2'b10 : 2'b01;
    return r;
  endfunction

endpackage

// File: rtl/axis_1553_msg_encoder_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 32
) (
  input  logic                     aclk,
  input  logic                     arstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;

  assign rd_data = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;

  // Storage array, written on accepted pushes only
  always_ff @(posedge aclk)
    if (push) mem[wp] <= wr_data;

  // Pointers and occupancy; reset flushes the contents
  always_ff @(posedge aclk)
    if (!arstn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end

endmodule

// File: rtl/axis_1553_msg_encoder.sv
// axis_1553_msg_encoder: buffered multi-word, dual-bus MIL-STD-1553 Manchester transmitter
module axis_1553_msg_encoder
  import encoder_1553_pkg::*;
#(
  parameter int CLOCK_SPEED = 4000000,
  parameter int FIFO_DEPTH = 32,
  parameter int GAP_US = 4,
  parameter int NUM_BUS = 2
) (
  input  logic                          aclk,
  input  logic                          arstn,
  input  logic [15:0]                   s_axis_tdata,
  input  logic [7:0]                    s_axis_tuser,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [2*NUM_BUS-1:0]          diff,
  output logic [NUM_BUS-1:0]            en_diff,
  output logic                          busy,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int H = CLOCK_SPEED / 2000000;
  localparam int G = GAP_US * 2 * H;
  localparam int CW = $clog2(G + H + 1);
  localparam logic [CW-1:0] H_END = CW'(H - 1);
  localparam logic [CW-1:0] H_PRE = CW'(H > 1 ? H - 2 : 0);
  localparam logic [CW-1:0] G_END = CW'(G - 1);
  localparam logic [5:0] LAST_HB = 6'(HALF_BITS_PER_WORD - 1);

  logic [24:0] rd;
  logic full, empty, push, pop, pop_pf;
  word_t fw, cur, pf;
  logic pf_v;
  state_t state, state_n;
  logic [39:0] sr, sr_n;
  logic [CW-1:0] cyc;
  logic [5:0] half;
  logic bus_q, bus_n;
  logic hb_end, last_hb, pre_last;
  logic [2*NUM_BUS-1:0] diff_n;
  logic [NUM_BUS-1:0] en_n;
  logic ur_n;
  logic unused;

  assign s_axis_tready = arstn && !full;
  assign push = s_axis_tvalid && s_axis_tready;

  sync_fifo #(.WIDTH(25), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk(aclk),
    .arstn(arstn),
    .push(push),
    .wr_data({s_axis_tlast, s_axis_tuser, s_axis_tdata}),
    .pop(pop),
    .rd_data(rd),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );

  assign fw = '{last: rd[24], sync: rd[16+TU_SYNC_LO +: 3], bus: rd[16+TU_BUS],
                inv_data: rd[16+TU_INV_DATA], inv_par: rd[16+TU_INV_PAR], data: rd[15:0]};
  assign unused = ^{rd[20], rd[18]};

  assign hb_end = cyc == H_END;
  assign last_hb = state == SEND && hb_end && half == LAST_HB;
  assign pre_last = state == SEND && (H == 1 ? hb_end && half == LAST_HB - 6'd1 : cyc == H_PRE && half == LAST_HB);
  assign pop_pf = state == SEND && !pf_v && !cur.last && !empty && !last_hb;
  assign pop = (state == IDLE && !empty) || pop_pf;

  // State register
  always_ff @(posedge aclk)
    if (!arstn) state <= IDLE;
    else state <= state_n;

  // Next state: a word continues the message only if it was prefetched before the final half-bit
  always_comb
    state_n = state == IDLE ? (empty ? IDLE : LOAD) :
              state == LOAD ? SEND :
              state == SEND ? (last_hb && (cur.last || !pf_v) ? GAP : SEND) :
              (cyc == G_END ? IDLE : GAP);

  // Shifter next value and bus latch; LOAD always begins a new message
  always_comb begin
    sr_n = state == LOAD ? build_word(cur) :
           last_hb && pf_v ? build_word(pf) :
           state == SEND && hb_end ? {sr[38:0], 1'b0} : sr;
    bus_n = state == LOAD ? (NUM_BUS > 1 && cur.bus) : bus_q;
  end

  // Word registers, prefetch slot and half-bit/cycle counters
  always_ff @(posedge aclk)
    if (!arstn) begin
      cur <= '0;
      pf <= '0;
      pf_v <= 1'b0;
      sr <= '0;
      cyc <= '0;
      half <= '0;
      bus_q <= 1'b0;
    end else begin
      if (state == IDLE && !empty) cur <= fw;
      else if (last_hb && pf_v) cur <= pf;
      if (pop_pf) pf <= fw;
      pf_v <= pop_pf || (pf_v && !last_hb);
      sr <= sr_n;
      cyc <= (state == SEND && !hb_end) || state == GAP ? cyc + 1'b1 : '0;
      half <= state != SEND || last_hb ? '0 : hb_end ? half + 6'd1 : half;
      bus_q <= bus_n;
    end

  // Output decode from next-cycle state so every output leaves a flop; underrun is looked ahead one cycle
  always_comb begin
    for (int n = 0; n < NUM_BUS; n++) begin
      en_n[n] = state_n == SEND && (n == 0 ? !bus_n : bus_n);
      diff_n[2*n] = en_n[n] && sr_n[39];
      diff_n[2*n+1] = en_n[n] && !sr_n[39];
    end
    ur_n = pre_last && !cur.last && !pf_v && !pop_pf;
  end

  // Output registers
  always_ff @(posedge aclk)
    if (!arstn) begin
      diff <= '0;
      en_diff <= '0;
      busy <= 1'b0;
      underrun <= 1'b0;
    end else begin
      diff <= diff_n;
      en_diff <= en_n;
      busy <= state_n != IDLE;
      underrun <= ur_n;
    end

endmodule
